// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an instruction-fetch read
// port (IF) and a load/store port (LS). Each access goes through three steps.
// IDLE picks a winner and latches its request. ACCESS drives the RAM for one
// cycle on a write, or for RD_LAT+1 cycles on a read. RESP pulses the
// winner's ack for one cycle.
//
// Optional build macro: ARB_FIXED_PRIO_EN
//    undefined : round-robin between IF and LS when both request
//    defined   : LS always wins a tie; IF may starve under continuous LS load
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch winner's addr/wdata/op
// ACCESS | RAM busy; ram_wr high only on a write; read data captured at end
// RESP   | one-cycle ack to the winner, then back to IDLE

module ram_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          ls_req,
   input  logic          ls_wr,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic [DW-1:0] ls_rdata,
   output logic          ls_ack,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_wr,
   input  logic [DW-1:0] ram_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Cycles left in ACCESS after the current one; a read stays RD_LAT extra cycles.
   localparam logic [2:0] RD_CNT = 3'(RD_LAT);

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          op_wr_q, op_wr_d;
   logic          win_ls_q, win_ls_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_data_q, ram_data_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] ls_rdata_q, ls_rdata_d;
   logic          grant_ls;

`ifdef ARB_FIXED_PRIO_EN
   // LS takes every grant it asks for.
   assign grant_ls = ls_req;
`else
   // Reset value 1 (LS) lets IF win the first tie.
   logic          last_ls_q, last_ls_d;

   assign grant_ls = ls_req & (~if_req | ~last_ls_q);

   // Round-robin history: which port won the most recent grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ls_q <= 1'b1;
      end else begin
         last_ls_q <= last_ls_d;
      end
   end

   // Update the history on every grant out of IDLE.
   always_comb begin
      last_ls_d = last_ls_q;
      if (state_q == ST_IDLE && (if_req || ls_req)) begin
         last_ls_d = grant_ls;
      end
   end
`endif

   // State, latched request and returned read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_wr_q    <= 1'b0;
         win_ls_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_wr_q    <= op_wr_d;
         win_ls_q   <= win_ls_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, count down in ACCESS, one cycle in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_wr_d    = op_wr_q;
      win_ls_d   = win_ls_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (if_req || ls_req) begin
               win_ls_d = grant_ls;
               if (grant_ls) begin
                  ram_addr_d = ls_addr;
                  ram_data_d = ls_wdata;
                  op_wr_d    = ls_wr;
                  cnt_d      = ls_wr ? 3'd0 : RD_CNT;
               end else begin
                  // IF carries no write data, so ram_data keeps its last value.
                  ram_addr_d = if_addr;
                  op_wr_d    = 1'b0;
                  cnt_d      = RD_CNT;
               end
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_RESP;
               if (!op_wr_q) begin
                  if (win_ls_q) begin
                     ls_rdata_d = ram_out;
                  end else begin
                     if_rdata_d = ram_out;
                  end
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Decoded straight from registers, so reset clears ram_wr and both acks at once.
   always_comb begin
      ram_wr = (state_q == ST_ACCESS) && op_wr_q;
      if_ack = (state_q == ST_RESP) && !win_ls_q;
      ls_ack = (state_q == ST_RESP) && win_ls_q;
   end

   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign if_rdata = if_rdata_q;
   assign ls_rdata = ls_rdata_q;

endmodule
